// File: rtl/sim_ctrl_pkg.sv
// Shared constants and types for the simulation-control MMIO responder:
// register offsets, STATUS bit positions, FSM state and a byte-strobe merge helper.
package sim_ctrl_pkg;

  localparam logic [4:0] OFF_RESULT  = 5'h00;
  localparam logic [4:0] OFF_DONE    = 5'h04;
  localparam logic [4:0] OFF_CONSOLE = 5'h08;
  localparam logic [4:0] OFF_CYCLE   = 5'h0C;
  localparam logic [4:0] OFF_STATUS  = 5'h10;

  localparam logic [31:0] DONE_MAGIC_DEF = 32'hDEAD_BEEF;

  localparam int ST_DONE    = 0;
  localparam int ST_TIMEOUT = 1;
  localparam int ST_PASS    = 2;
  localparam int ST_EMPTY   = 3;
  localparam int ST_FULL    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sim_ctrl_mmio_if.sv
// CPU data-bus request/response channel: valid/ready request, one-cycle response pulse.
interface sim_ctrl_mmio_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered pointers with an extra wrap bit; no push-to-pop bypass,
// so a byte pushed into an empty FIFO becomes visible the following cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only observed behind the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sim_ctrl_mmio.sv
// Simulation-control responder: RESULT/DONE capture, console byte FIFO, cycle/timeout counter.
// One request outstanding, response exactly one cycle after accept; console writes stall when the FIFO is full.
module sim_ctrl_mmio
  import sim_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_1000,
  parameter logic [31:0] DONE_MAGIC     = DONE_MAGIC_DEF,
  parameter logic [31:0] EXPECTED       = 32'd2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd10000,
  parameter int          FIFO_DEPTH     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  sim_ctrl_mmio_if.slave bus,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic [7:0]     tx_data,
  output logic           done,
  output logic           pass,
  output logic           timeout,
  output logic [31:0]    result
);

  state_t      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        in_window, aligned, reg_hit, console_wr, accept;
  logic [4:0]  off;
  logic [31:0] status, rd_val;
  logic        timeout_hit;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;

  always_comb begin
    off        = bus.req_addr[4:0];
    in_window  = (bus.req_addr[31:5] == BASE_ADDR[31:5]);
    aligned    = (bus.req_addr[1:0] == 2'b00);
    reg_hit    = in_window && aligned && (off <= OFF_STATUS);
    console_wr = reg_hit && bus.req_we && (off == OFF_CONSOLE);
  end

  // Only a console write that would actually push is held off by a full FIFO.
  assign bus.req_ready = (state_q == IDLE) &&
                         !(console_wr && bus.req_wstrb[0] && fifo_full);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    status              = '0;
    status[ST_DONE]     = done_q;
    status[ST_TIMEOUT]  = timeout_q;
    status[ST_PASS]     = pass_q;
    status[ST_EMPTY]    = fifo_empty;
    status[ST_FULL]     = fifo_full;
  end

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_RESULT: rd_val = result_q;
      OFF_DONE:   rd_val = {31'b0, done_q};
      OFF_CYCLE:  rd_val = cnt_q;
      OFF_STATUS: rd_val = status;
      default:    rd_val = '0;
    endcase
  end

  assign timeout_hit = (cnt_q == TIMEOUT_CYCLES) && !done_q;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    fifo_push = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RESP;
          err_d   = !reg_hit;
          rdata_d = (reg_hit && !bus.req_we) ? rd_val : 32'h0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept && reg_hit && bus.req_we) begin
      case (off)
        OFF_RESULT: begin
          if (!done_q) result_d = apply_wstrb(result_q, bus.req_wdata, bus.req_wstrb);
        end
        OFF_DONE: begin
          if (!done_q && bus.req_wstrb == 4'hF && bus.req_wdata == DONE_MAGIC) begin
            done_d = 1'b1;
            // Judged against RESULT as it stood before this cycle's writes.
            pass_d = (result_q == EXPECTED) && !timeout_q;
          end
        end
        OFF_CONSOLE: fifo_push = bus.req_wstrb[0];
        default: ;
      endcase
    end

    if (timeout_hit) timeout_d = 1'b1;

    if (!(done_q || timeout_q || timeout_hit) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign fifo_pop = tx_valid && tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (bus.req_wdata[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign tx_valid      = !fifo_empty;
  assign tx_data       = fifo_rdata;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign result        = result_q;

endmodule

// File: tb/tb_sim_ctrl_mmio.sv
// Directed bench for sim_ctrl_mmio: requests push expected responses/bytes into queues,
// independent monitors pop and compare whenever the DUT presents a response or a console byte.
module tb_sim_ctrl_mmio;

  localparam logic [31:0] B     = 32'h8000_1000;
  localparam logic [31:0] TO    = 32'd100;
  localparam logic [31:0] MAGIC = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_valid, tx_ready, done, pass, timeout;
  logic [7:0]  tx_data;
  logic [31:0] result;

  always #5 clk = ~clk;

  sim_ctrl_mmio_if bus();

  sim_ctrl_mmio #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .done     (done),
    .pass     (pass),
    .timeout  (timeout),
    .result   (result)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       name;
  } rsp_exp_t;

  rsp_exp_t   rsp_q[$];
  logic [7:0] tx_q[$];
  int n_pass  = 0;
  int n_total = 0;
  int tb_cyc  = 0;
  int since_rst = 0;

  always @(posedge clk) begin
    tb_cyc    <= tb_cyc + 1;
    since_rst <= rst_n ? since_rst + 1 : 0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic fail_bound(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Response monitor: checks data, error flag and one-cycle latency.
  always @(posedge clk) begin : rsp_mon
    rsp_exp_t e;
    #1;
    if (bus.rsp_valid) begin
      if (rsp_q.size() == 0) begin
        fail_bound("unexpected response");
      end else begin
        e = rsp_q.pop_front();
        chk({e.name, " rdata"},   bus.rsp_rdata, e.rdata);
        chk({e.name, " err"},     bus.rsp_err,   e.err);
        chk({e.name, " latency"}, tb_cyc,        e.cyc);
      end
    end
  end

  always @(negedge clk) begin : tx_mon
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) fail_bound("unexpected console byte");
      else chk("console byte", tx_data, tx_q.pop_front());
    end
  end

  task automatic xfer(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int waited;
    rsp_exp_t e;
    waited = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
    #1;
    while (!bus.req_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bus.req_ready) begin
      fail_bound({name, " accept"});
      bus.req_valid = 1'b0;
      return;
    end
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = tb_cyc + 1;
    e.name  = name;
    rsp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic exp_err = 1'b0);
    xfer(name, 1'b1, addr, data, strb, 32'h0, exp_err);
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp,
                    input logic exp_err = 1'b0);
    xfer(name, 1'b0, addr, 32'h0, 4'h0, exp, exp_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    tx_ready      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset flags", {done, pass, timeout, tx_valid, bus.rsp_valid, bus.rsp_err}, 64'h0);
    chk("reset result", result, 64'h0);
    rst_n = 1'b1;
  endtask

  task automatic drain_tx(input string name);
    int waited;
    waited = 0;
    while (tx_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    if (tx_q.size() != 0) fail_bound(name);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] cyc_done;
    int waited;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    tx_ready      = 1'b0;

    // 1: passing run, counter freezes at done
    do_reset();
    wr("t1 result", B + 32'h0, 32'd2, 4'hF);
    chk("t1 result port", result, 32'd2);
    wr("t1 done", B + 32'h4, MAGIC, 4'hF);
    cyc_done = since_rst;
    chk("t1 done", done, 1);
    chk("t1 pass", pass, 1);
    repeat (5) @(posedge clk);
    rd("t1 cycle", B + 32'hC, cyc_done);
    rd("t1 status", B + 32'h10, 32'h0D);
    rd("t1 cycle again", B + 32'hC, cyc_done);

    // 2: only the full-word magic write ends the run; RESULT locks at done
    do_reset();
    wr("t2 result full", B + 32'h0, 32'h1122_3344, 4'hF);
    wr("t2 result strb", B + 32'h0, 32'hAABB_CCDD, 4'b0101);
    rd("t2 result merged", B + 32'h0, 32'h11BB_33DD);
    wr("t2 result 5", B + 32'h0, 32'd5, 4'hF);
    wr("t2 bad magic", B + 32'h4, 32'h1234_5678, 4'hF);
    chk("t2 done after bad magic", done, 0);
    wr("t2 partial strb", B + 32'h4, MAGIC, 4'h3);
    chk("t2 done after partial", done, 0);
    wr("t2 magic", B + 32'h4, MAGIC, 4'hF);
    chk("t2 done", done, 1);
    chk("t2 pass", pass, 0);
    wr("t2 result locked", B + 32'h0, 32'd2, 4'hF);
    rd("t2 result read", B + 32'h0, 32'd5);

    // 3: console FIFO fills, stalls the ninth write, drains in order
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(8'(8'h41 + i));
      wr("t3 console", B + 32'h8, 32'(32'h41 + i), 4'h1);
    end
    rd("t3 status full", B + 32'h10, 32'h10);
    tx_q.push_back(8'h49);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = B + 32'h8;
    bus.req_wdata = 32'h49;
    bus.req_wstrb = 4'h1;
    #1;
    chk("t3 stall on full", bus.req_ready, 0);
    @(posedge clk);
    #1;
    chk("t3 still stalled", bus.req_ready, 0);
    tx_ready = 1'b1;
    wr("t3 console I", B + 32'h8, 32'h49, 4'h1);
    drain_tx("t3 drain");
    rd("t3 status empty", B + 32'h10, 32'h08);
    tx_q.push_back(8'h5A);
    wr("t3 console Z", B + 32'h8, 32'h5A, 4'h1);
    chk("t3 tx_valid after push", tx_valid, 1);
    drain_tx("t3 drain Z");
    rd("t3 console reads 0", B + 32'h8, 32'h0);

    // 4: error decode, no side effects
    do_reset();
    wr("t4 result", B + 32'h0, 32'h77, 4'hF);
    rd("t4 off14", B + 32'h14, 32'h0, 1'b1);
    rd("t4 misaligned rd", B + 32'h2, 32'h0, 1'b1);
    wr("t4 misaligned wr", B + 32'h2, 32'hFFFF_FFFF, 4'hF, 1'b1);
    wr("t4 outside wr", 32'h8000_2000, 32'h55, 4'hF, 1'b1);
    wr("t4 off18 wr", B + 32'h18, 32'h66, 4'hF, 1'b1);
    rd("t4 off1C", B + 32'h1C, 32'h0, 1'b1);
    wr("t4 misaligned console", B + 32'h9, 32'h41, 4'hF, 1'b1);
    chk("t4 no console push", tx_valid, 0);
    rd("t4 result kept", B + 32'h0, 32'h77);
    chk("t4 result port", result, 32'h77);

    // 5: timeout before done; late done does not pass
    do_reset();
    wr("t5 result", B + 32'h0, 32'd2, 4'hF);
    waited = 0;
    while (!timeout && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!timeout) fail_bound("t5 timeout");
    rd("t5 cycle", B + 32'hC, TO);
    rd("t5 status", B + 32'h10, 32'h0A);
    wr("t5 late done", B + 32'h4, MAGIC, 4'hF);
    chk("t5 done", done, 1);
    chk("t5 pass", pass, 0);
    rd("t5 status after done", B + 32'h10, 32'h0B);

    // 6: reset while a response is on the bus
    do_reset();
    wr("t6 result", B + 32'h0, 32'd2, 4'hF);
    wr("t6 done", B + 32'h4, MAGIC, 4'hF);
    chk("t6 pass before reset", pass, 1);
    rd("t6 status", B + 32'h10, 32'h0D);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6 rsp_valid after reset", bus.rsp_valid, 0);
    chk("t6 flags after reset", {done, pass, timeout}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("t6 result after reset", B + 32'h0, 32'h0);
    rd("t6 status after reset", B + 32'h10, 32'h08);

    repeat (5) @(posedge clk);
    chk("rsp queue drained", rsp_q.size(), 0);
    chk("tx queue drained", tx_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
